// File: rtl/icache_fetch_unit.sv
// Direct-mapped instruction cache with a counted-burst line fill controller.
// Hits return data in the same cycle; misses stall the front end while the line is fetched.
module icache_fetch_unit #(
    parameter int INDEX_BITS  = 5,
    parameter int OFFSET_BITS = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_req,
    input  logic [15:0] pc_addr,
    input  logic        inv_all,
    output logic [15:0] instr_out,
    output logic        instr_valid,
    output logic        miss_stall,
    output logic        mem_rd_en,
    output logic [15:0] mem_addr,
    input  logic        mem_data_valid,
    input  logic [15:0] mem_data,
    output logic [15:0] miss_count
);
    localparam int TW    = 16 - INDEX_BITS - OFFSET_BITS - 1;
    localparam int LINES = 1 << INDEX_BITS;
    localparam int WORDS = 1 << OFFSET_BITS;

    typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

    logic [15:0]   data_mem [0:LINES*WORDS-1];
    logic [TW-1:0] tag_mem  [0:LINES-1];

    state_t                 state_q, state_d;
    logic [LINES-1:0]       valid_q, valid_d;
    logic [TW-1:0]          fill_tag_q, fill_tag_d;
    logic [INDEX_BITS-1:0]  fill_index_q, fill_index_d;
    logic [OFFSET_BITS:0]   req_cnt_q, req_cnt_d;
    logic [OFFSET_BITS-1:0] rcv_cnt_q, rcv_cnt_d;
    logic [15:0]            miss_count_q, miss_count_d;

    logic [TW-1:0]          pc_tag;
    logic [INDEX_BITS-1:0]  pc_index;
    logic [OFFSET_BITS-1:0] pc_offset;
    logic                   hit, miss, data_we, fill_done;
    logic                   unused_pc_bit;

    assign pc_tag        = pc_addr[15 -: TW];
    assign pc_index      = pc_addr[OFFSET_BITS+1 +: INDEX_BITS];
    assign pc_offset     = pc_addr[1 +: OFFSET_BITS];
    assign unused_pc_bit = pc_addr[0];
    assign miss_count    = miss_count_q;

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        fill_tag_d   = fill_tag_q;
        fill_index_d = fill_index_q;
        req_cnt_d    = req_cnt_q;
        rcv_cnt_d    = rcv_cnt_q;
        miss_count_d = miss_count_q;
        instr_valid  = 1'b0;
        instr_out    = 16'h0000;
        miss_stall   = 1'b0;
        mem_rd_en    = 1'b0;
        mem_addr     = 16'h0000;

        hit       = fetch_req && valid_q[pc_index] && (tag_mem[pc_index] == pc_tag);
        miss      = fetch_req && !hit;
        data_we   = (state_q == FILL) && mem_data_valid;
        fill_done = data_we && (rcv_cnt_q == {OFFSET_BITS{1'b1}});

        if (inv_all) begin
            valid_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (hit) begin
                    instr_valid = 1'b1;
                    instr_out   = data_mem[{pc_index, pc_offset}];
                end else if (miss) begin
                    miss_stall   = 1'b1;
                    fill_tag_d   = pc_tag;
                    fill_index_d = pc_index;
                    req_cnt_d    = '0;
                    rcv_cnt_d    = '0;
                    if (miss_count_q != 16'hFFFF) begin
                        miss_count_d = miss_count_q + 16'd1;
                    end
                    state_d = FILL;
                end
            end
            FILL: begin
                miss_stall = 1'b1;
                // MSB of req_cnt set means all line words have been requested
                if (!req_cnt_q[OFFSET_BITS]) begin
                    mem_rd_en = 1'b1;
                    mem_addr  = {fill_tag_q, fill_index_q, req_cnt_q[OFFSET_BITS-1:0], 1'b0};
                    req_cnt_d = req_cnt_q + (OFFSET_BITS+1)'(1);
                end
                if (data_we) begin
                    rcv_cnt_d = rcv_cnt_q + OFFSET_BITS'(1);
                end
                // The completing line wins over a simultaneous invalidate-all
                if (fill_done) begin
                    valid_d[fill_index_q] = 1'b1;
                    state_d               = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!rst_n) begin
            instr_valid = 1'b0;
            instr_out   = 16'h0000;
            miss_stall  = 1'b0;
            mem_rd_en   = 1'b0;
            mem_addr    = 16'h0000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            fill_tag_q   <= '0;
            fill_index_q <= '0;
            req_cnt_q    <= '0;
            rcv_cnt_q    <= '0;
            miss_count_q <= 16'h0000;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            fill_tag_q   <= fill_tag_d;
            fill_index_q <= fill_index_d;
            req_cnt_q    <= req_cnt_d;
            rcv_cnt_q    <= rcv_cnt_d;
            miss_count_q <= miss_count_d;
        end
    end

    // Storage arrays are not reset; valid bits alone decide whether a line is usable
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_mem[{fill_index_q, rcv_cnt_q}] <= mem_data;
        end
        if (fill_done) begin
            tag_mem[fill_index_q] <= fill_tag_q;
        end
    end
endmodule

// File: tb/tb_icache_fetch_unit.sv
// Bench for icache_fetch_unit: directed scenarios plus random accesses against a
// line-level cache model and a latency-programmable in-order memory responder.
module tb_icache_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req;
    logic [15:0] pc_addr;
    logic        inv_all;
    logic [15:0] instr_out;
    logic        instr_valid;
    logic        miss_stall;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic        mem_data_valid = 1'b0;
    logic [15:0] mem_data = 16'h0000;
    logic [15:0] miss_count;

    always #5 clk = ~clk;

    icache_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_req      (fetch_req),
        .pc_addr        (pc_addr),
        .inv_all        (inv_all),
        .instr_out      (instr_out),
        .instr_valid    (instr_valid),
        .miss_stall     (miss_stall),
        .mem_rd_en      (mem_rd_en),
        .mem_addr       (mem_addr),
        .mem_data_valid (mem_data_valid),
        .mem_data       (mem_data),
        .miss_count     (miss_count)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory image and responder: request seen in cycle k answers no earlier than k+mem_lat
    logic [15:0] mem_img [0:32767];
    int          mem_lat     = 4;
    bit          gap_mode    = 1'b0;
    int          last_deliver = -1;
    logic [15:0] req_q [$];
    int          due_q [$];

    always @(negedge clk) begin
        logic [15:0] ra;
        if (!rst_n) begin
            req_q.delete();
            due_q.delete();
            mem_data_valid = 1'b0;
            mem_data       = 16'h0000;
        end else begin
            if (mem_rd_en) begin
                req_q.push_back(mem_addr);
                due_q.push_back(cyc + mem_lat);
            end
            if (req_q.size() > 0 && due_q[0] <= cyc && (!gap_mode || (cyc % 2) == 0)) begin
                ra             = req_q[0];
                mem_data_valid = 1'b1;
                mem_data       = mem_img[ra[15:1]];
                void'(req_q.pop_front());
                void'(due_q.pop_front());
                last_deliver   = cyc;
            end else begin
                mem_data_valid = 1'b0;
                mem_data       = 16'($urandom);
            end
        end
    end

    // Line-level cache model
    bit          m_valid [32];
    logic [6:0]  m_tag   [32];
    int          m_miss = 0;

    function automatic bit m_hit(input logic [15:0] a);
        return m_valid[a[8:4]] && (m_tag[a[8:4]] == a[15:9]);
    endfunction

    task automatic m_clear();
        for (int k = 0; k < 32; k++) m_valid[k] = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_cycle(input bit inv);
        fetch_req = 1'b0;
        inv_all   = inv;
        @(negedge clk);
        chk("idle_stall", miss_stall, 0);
        chk("idle_valid", instr_valid, 0);
        chk("idle_out", instr_out, 0);
        chk("idle_rd", mem_rd_en, 0);
        @(posedge clk); #1;
        inv_all = 1'b0;
        if (inv) m_clear();
    endtask

    // One fetch; on a miss, follows the fill and checks requests, timing and the refill hit
    task automatic access(input logic [15:0] a, input int inv_at);
        int          i;
        int          slen;
        bit          inv_seen;
        logic [15:0] base;
        fetch_req = 1'b1;
        pc_addr   = a;
        @(negedge clk);
        if (m_hit(a)) begin
            chk("hit_valid", instr_valid, 1);
            chk("hit_data", instr_out, mem_img[a[15:1]]);
            chk("hit_stall", miss_stall, 0);
            chk("hit_rd", mem_rd_en, 0);
        end else begin
            chk("miss_stall", miss_stall, 1);
            chk("miss_valid", instr_valid, 0);
            chk("miss_out", instr_out, 0);
            base     = {a[15:4], 4'h0};
            slen     = 1;
            i        = 0;
            inv_seen = 1'b0;
            @(posedge clk); #1;
            while (1) begin
                @(negedge clk);
                i++;
                if (!miss_stall || i > 400) break;
                slen++;
                chk("fill_valid", instr_valid, 0);
                chk("fill_rd", mem_rd_en, (i <= 8));
                if (i <= 8) chk("fill_addr", mem_addr, base + 16'(2 * (i - 1)));
                if (i == inv_at) begin
                    inv_all  = 1'b1;
                    inv_seen = 1'b1;
                end
                @(posedge clk); #1;
                inv_all = 1'b0;
            end
            chk("fill_timeout", (i <= 400), 1);
            chk("release_cyc", cyc, last_deliver + 1);
            if (!gap_mode) chk("stall_len", slen, 9 + mem_lat);
            if (inv_seen) m_clear();
            m_valid[a[8:4]] = 1'b1;
            m_tag[a[8:4]]   = a[15:9];
            if (m_miss < 65535) m_miss++;
            chk("refill_valid", instr_valid, 1);
            chk("refill_data", instr_out, mem_img[a[15:1]]);
            chk("refill_stall", miss_stall, 0);
        end
        chk("miss_count", miss_count, m_miss);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          r;
        int          inv_at;
        logic [15:0] a;

        for (int k = 0; k < 32768; k++) mem_img[k] = 16'($urandom);
        m_clear();
        rst_n     = 1'b0;
        fetch_req = 1'b1;
        pc_addr   = 16'h0000;
        inv_all   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", instr_valid, 0);
        chk("rst_stall", miss_stall, 0);
        chk("rst_rd", mem_rd_en, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_out", instr_out, 0);
        chk("rst_count", miss_count, 0);
        fetch_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        mem_lat = 4;
        access(16'h0000, 0);
        access(16'h000A, 0);
        access(16'h0200, 0);
        access(16'h0000, 0);

        idle_cycle(1'b1);
        access(16'h0000, 0);

        access(16'h0010, 0);
        access(16'h0020, 8 + mem_lat);
        access(16'h0024, 0);
        access(16'h0010, 0);
        access(16'h0030, 3);
        access(16'h0020, 0);
        access(16'h0032, 0);

        // Asynchronous reset in the middle of a fill
        fetch_req = 1'b1;
        pc_addr   = 16'h0040;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_stall", miss_stall, 0);
        chk("midrst_rd", mem_rd_en, 0);
        chk("midrst_addr", mem_addr, 0);
        chk("midrst_valid", instr_valid, 0);
        chk("midrst_count", miss_count, 0);
        fetch_req = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_clear();
        m_miss = 0;
        @(posedge clk); #1;
        access(16'h0040, 0);

        gap_mode = 1'b1;
        access(16'h0050, 0);
        access(16'h0056, 0);
        gap_mode = 1'b0;

        for (int n = 0; n < 40; n++) begin
            mem_lat  = $urandom_range(1, 6);
            gap_mode = ($urandom_range(0, 3) == 0);
            r        = $urandom_range(0, 9);
            if (r == 0) begin
                idle_cycle(1'b1);
            end else if (r == 1) begin
                idle_cycle(1'b0);
            end else begin
                a      = {7'($urandom_range(0, 2)), 5'($urandom_range(0, 3)), 3'($urandom), 1'b0};
                inv_at = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 8 + mem_lat) : 0;
                access(a, inv_at);
            end
        end
        gap_mode = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
